pad_reader: RTL and testbench

PAD_READER -- requirements
Module: pad_reader

---
 rtl/pad_pkg.sv | 42 ++++
 rtl/pad_reader_if.sv | 29 ++
 rtl/sync_ff.sv | 34 +++
 rtl/pad_reader.sv | 207 ++++++++++++++++++++
 tb/tb_pad_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_pkg.sv
// ============================================================================
// Module      : pad_pkg
// Description : Shared types and helpers for the pad reader: FSM state
//               encoding and the serial-position to button-bit map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pad_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_t;

    localparam int c_num_buttons = 8;

    // Serial arrival order is A,B,SL,ST,Up,Dn,Lt,Rt; the button register is
    // ordered {ST,SL,B,A,Dn,Up,Lt,Rt}.
    function automatic logic [2:0] ser_to_btn(input logic [2:0] ser_idx);
        logic [2:0] btn_idx;
        btn_idx = 3'd0;
        case (ser_idx)
            3'd0: btn_idx = 3'd4;  // A
            3'd1: btn_idx = 3'd5;  // B
            3'd2: btn_idx = 3'd6;  // Select
            3'd3: btn_idx = 3'd7;  // Start
            3'd4: btn_idx = 3'd2;  // Up
            3'd5: btn_idx = 3'd3;  // Down
            3'd6: btn_idx = 3'd1;  // Left
            3'd7: btn_idx = 3'd0;  // Right
            default: btn_idx = 3'd0;
        endcase
        return btn_idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pad_reader_if.sv
// ============================================================================
// Module      : pad_reader_if
// Description : Three-wire link to an external shift-register game pad.
//               master = reader side, slave = pad side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pad_reader_if;

    logic pad_latch;
    logic pad_clk;
    logic pad_data;

    modport master (
        output pad_latch,
        output pad_clk,
        input  pad_data
    );

    modport slave (
        input  pad_latch,
        input  pad_clk,
        output pad_data
    );

endinterface

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module      : sync_ff
// Description : Two-flop synchronizer for a single asynchronous bit. Resets
//               to 1 so an idle/floating pad line reads as "released".
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pad_reader.sv
// ============================================================================
// Module      : pad_reader
// Description : Periodically scans an 8-bit shift-register game pad, remaps
//               the serial bits to the joypad register order and applies a
//               two-scan debounce before updating the button state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_reader
    import pad_pkg::*;
#(
    parameter int CLK_DIV     = 8,
    parameter int POLL_PERIOD = 16384
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    pad_reader_if.master       pad,
    output logic [7:0]         buttons,
    output logic               scan_done
);

    localparam int                  c_idle_w    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(POLL_PERIOD - 1);
    localparam logic [c_idle_w-1:0] c_idle_one  = c_idle_w'(1);
    localparam logic [7:0]          c_half_last = 8'(CLK_DIV - 1);

    // Sequencer state and counters
    pad_state_t          r_state;
    pad_state_t          w_state_nxt;
    logic [c_idle_w-1:0] r_idle_cnt;
    logic [c_idle_w-1:0] w_idle_nxt;
    logic [7:0]          r_half_cnt;
    logic [7:0]          w_half_nxt;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_nxt;
    // Phase within a two-half-period slot: LATCH first/second half,
    // SHIFT low (0) / high (1). Lets LATCH span 2*CLK_DIV with an 8-bit counter.
    logic                r_phase;
    logic                w_phase_nxt;
    logic                w_sample;

    // Outputs and scan data
    logic                r_pad_latch;
    logic                r_pad_clk;
    logic                r_scan_done;
    logic [7:0]          r_scan;
    logic [7:0]          r_prev;
    logic [7:0]          r_buttons;
    logic                w_pad_sync;

    sync_ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (pad.pad_data),
        .o_q     (w_pad_sync)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter reloads and sample strobe
    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_cnt;
        w_half_nxt  = r_half_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_phase_nxt = r_phase;
        w_sample    = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_idle_cnt == c_idle_last) begin
                    // Counter saturates here until en allows a scan
                    if (en) begin
                        w_state_nxt = LATCH;
                        w_half_nxt  = 8'd0;
                        w_bit_nxt   = 3'd0;
                        w_phase_nxt = 1'b0;
                    end
                end else begin
                    w_idle_nxt = r_idle_cnt + c_idle_one;
                end
            end

            LATCH: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    w_idle_nxt  = '0;
                    w_half_nxt  = 8'd0;
                    w_bit_nxt   = 3'd0;
                    w_phase_nxt = 1'b0;
                end else if (r_half_cnt == c_half_last) begin
                    w_half_nxt = 8'd0;
                    if (r_phase) begin
                        w_state_nxt = SHIFT;
                        w_bit_nxt   = 3'd0;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_phase_nxt = 1'b1;
                    end
                end else begin
                    w_half_nxt = r_half_cnt + 8'd1;
                end
            end

            SHIFT: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    w_idle_nxt  = '0;
                    w_half_nxt  = 8'd0;
                    w_bit_nxt   = 3'd0;
                    w_phase_nxt = 1'b0;
                end else if (r_half_cnt == c_half_last) begin
                    w_half_nxt = 8'd0;
                    if (!r_phase) begin
                        // Last low cycle: data has been stable since the
                        // previous rising pad_clk, so sample now
                        w_sample    = 1'b1;
                        w_phase_nxt = 1'b1;
                    end else if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = DONE;
                        w_bit_nxt   = 3'd0;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                        w_phase_nxt = 1'b0;
                    end
                end else begin
                    w_half_nxt = r_half_cnt + 8'd1;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
                w_idle_nxt  = '0;
                w_half_nxt  = 8'd0;
                w_bit_nxt   = 3'd0;
                w_phase_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = IDLE;
                w_idle_nxt  = '0;
                w_half_nxt  = 8'd0;
                w_bit_nxt   = 3'd0;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    // Counters and pad-facing strobes; strobes are decoded from the next
    // state so they line up cycle-for-cycle with the registered state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt  <= '0;
            r_half_cnt  <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_phase     <= 1'b0;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b1;
            r_scan_done <= 1'b0;
        end else begin
            r_idle_cnt  <= w_idle_nxt;
            r_half_cnt  <= w_half_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_phase     <= w_phase_nxt;
            r_pad_latch <= (w_state_nxt == LATCH);
            r_pad_clk   <= !((w_state_nxt == SHIFT) && !w_phase_nxt);
            r_scan_done <= (w_state_nxt == DONE);
        end
    end

    // Scan capture and two-scan debounce; buttons move only on a DONE edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan    <= 8'hFF;
            r_prev    <= 8'hFF;
            r_buttons <= 8'hFF;
        end else begin
            if (w_sample) begin
                r_scan[ser_to_btn(r_bit_cnt)] <= w_pad_sync;
            end
            if (r_state == DONE) begin
                r_prev <= r_scan;
                if (r_scan == r_prev) begin
                    r_buttons <= r_scan;
                end
            end
        end
    end

    assign pad.pad_latch = r_pad_latch;
    assign pad.pad_clk   = r_pad_clk;
    assign buttons       = r_buttons;
    assign scan_done     = r_scan_done;

endmodule

`default_nettype wire

// File: tb/tb_pad_reader.sv
// ============================================================================
// Module      : tb_pad_reader
// Description : Self-checking bench for pad_reader with a behavioural
//               shift-register pad and a debounce reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pad_reader;

    localparam int CLK_DIV     = 4;
    localparam int POLL_PERIOD = 64;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       en      = 1'b1;
    logic [7:0] buttons;
    logic       scan_done;

    pad_reader_if pad ();

    pad_reader #(
        .CLK_DIV     (CLK_DIV),
        .POLL_PERIOD (POLL_PERIOD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .pad       (pad),
        .buttons   (buttons),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    // Pad model: parallel load while latched, shift toward bit 0 on rising pad_clk
    logic [7:0] pad_word = 8'hFF;
    logic [7:0] pad_sr   = 8'hFF;
    logic       pclk_q   = 1'b1;

    always @(posedge clk) begin
        pclk_q <= pad.pad_clk;
        if (pad.pad_latch)
            pad_sr <= pad_word;
        else if (pad.pad_clk && !pclk_q)
            pad_sr <= {1'b1, pad_sr[7:1]};
    end

    assign pad.pad_data = pad_sr[0];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] m_prev = 8'hFF;
    logic [7:0] m_btn  = 8'hFF;

    // serial bit i (A,B,SL,ST,Up,Dn,Lt,Rt) -> {ST,SL,B,A,Dn,Up,Lt,Rt}
    function automatic logic [7:0] remap(input logic [7:0] s);
        logic [7:0] b;
        b[4] = s[0]; b[5] = s[1]; b[6] = s[2]; b[7] = s[3];
        b[2] = s[4]; b[3] = s[5]; b[1] = s[6]; b[0] = s[7];
        return b;
    endfunction

    task automatic push_scan(input logic [7:0] serial);
        logic [7:0] b;
        pad_word = serial;
        b = remap(serial);
        if (b == m_prev) m_btn = b;
        m_prev = b;
        exp_q.push_back(m_btn);
    endtask

    task automatic wait_latch(input int budget, output int n);
        n = 0;
        while (pad.pad_latch !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for scan_done, then one more cycle, and pops the expected value
    task automatic finish_scan(output logic [7:0] got, output logic [7:0] want,
                               output bit ok, output bit moved, output logic sd_after);
        logic [7:0] start;
        ok    = 1'b0;
        moved = 1'b0;
        start = buttons;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (buttons !== start) moved = 1'b1;
            if (scan_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        sd_after = scan_done;
        got      = buttons;
        want     = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        en      = 1'b1;
        push_scan(8'hFF);
        repeat (3) @(negedge clk);
        total++;
        if ({pad.pad_latch, pad.pad_clk, scan_done} !== 3'b010) begin
            bad++;
            $display("FAIL reset_ctrl: latch/clk/done=%b required 010",
                     {pad.pad_latch, pad.pad_clk, scan_done});
        end
        total++;
        if (buttons !== 8'hFF) begin
            bad++;
            $display("FAIL reset_buttons: got %h required ff", buttons);
        end
        reset_n = 1'b1;
        wait_latch(200, n);
        total++;
        if (n !== POLL_PERIOD) begin
            bad++;
            $display("FAIL first_latch: %0d cycles required %0d", n, POLL_PERIOD);
        end
    endtask

    task automatic test_idle_scan();
        int lat, pulses, badlen, run, elapsed, n;
        bit clk_bad;
        logic [7:0] want;
        lat = 0; clk_bad = 0; pulses = 0; badlen = 0; run = 0;
        while (pad.pad_latch === 1'b1 && lat < 100) begin
            if (pad.pad_clk !== 1'b1) clk_bad = 1'b1;
            lat++;
            @(negedge clk);
        end
        elapsed = lat;
        total++;
        if (lat !== 2 * CLK_DIV || clk_bad) begin
            bad++;
            $display("FAIL latch_width: %0d cycles clk_low=%0d required %0d clk_low=0",
                     lat, clk_bad, 2 * CLK_DIV);
        end
        for (int i = 0; i < 200 && scan_done !== 1'b1; i++) begin
            if (pad.pad_clk === 1'b0) run++;
            else if (run > 0) begin
                pulses++;
                if (run != CLK_DIV) badlen++;
                run = 0;
            end
            elapsed++;
            @(negedge clk);
        end
        total++;
        if (pulses !== 8 || badlen !== 0) begin
            bad++;
            $display("FAIL clk_pulses: %0d pulses %0d wrong length required 8 and 0",
                     pulses, badlen);
        end
        total++;
        if (elapsed !== 18 * CLK_DIV) begin
            bad++;
            $display("FAIL scan_len: %0d cycles required %0d", elapsed, 18 * CLK_DIV);
        end
        @(negedge clk);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (buttons !== want || scan_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_scan1: buttons=%h done=%b required %h 0",
                     buttons, scan_done, want);
        end
        push_scan(8'hFF);
        n = 1;
        while (scan_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== POLL_PERIOD + 18 * CLK_DIV + 1) begin
            bad++;
            $display("FAIL done_period: %0d cycles required %0d",
                     n, POLL_PERIOD + 18 * CLK_DIV + 1);
        end
        @(negedge clk);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (buttons !== want) begin
            bad++;
            $display("FAIL idle_scan2: buttons=%h required %h", buttons, want);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] got, want, pat[3];
        bit ok, moved;
        logic sd;
        pat[0] = 8'hF7; pat[1] = 8'hFF; pat[2] = 8'hF7;
        for (int k = 0; k < 3; k++) begin
            push_scan(pat[k]);
            finish_scan(got, want, ok, moved, sd);
            total++;
            if (!ok || moved || got !== want || got !== 8'hFF || sd !== 1'b0) begin
                bad++;
                $display("FAIL bounce_%0d: ok=%0d moved=%0d buttons=%h done=%b required 1 0 %h 0",
                         k, ok, moved, got, sd, want);
            end
        end
    endtask

    task automatic test_press_a();
        logic [7:0] got, want;
        bit ok, moved;
        logic sd;
        for (int k = 0; k < 2; k++) begin
            push_scan(8'hFE);
            finish_scan(got, want, ok, moved, sd);
            total++;
            if (!ok || moved || got !== want || sd !== 1'b0) begin
                bad++;
                $display("FAIL press_a_%0d: ok=%0d moved=%0d buttons=%h done=%b required 1 0 %h 0",
                         k, ok, moved, got, sd, want);
            end
        end
        total++;
        if (buttons !== 8'hEF) begin
            bad++;
            $display("FAIL press_a_final: buttons=%h required ef", buttons);
        end
    endtask

    task automatic test_abort();
        int n, falls;
        logic prev_clk;
        logic [7:0] held, got, want;
        bit ok, moved, spurious;
        logic sd;
        pad_word = 8'hFF;
        held     = buttons;
        wait_latch(300, n);
        falls    = 0;
        prev_clk = pad.pad_clk;
        for (int i = 0; i < 200 && falls < 4; i++) begin
            @(negedge clk);
            if (prev_clk === 1'b1 && pad.pad_clk === 1'b0) falls++;
            prev_clk = pad.pad_clk;
        end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        total++;
        if (pad.pad_clk !== 1'b1 || pad.pad_latch !== 1'b0 || falls !== 4) begin
            bad++;
            $display("FAIL abort_pins: clk=%b latch=%b falls=%0d required 1 0 4",
                     pad.pad_clk, pad.pad_latch, falls);
        end
        en = 1'b1;
        spurious = 1'b0;
        n = 0;
        while (pad.pad_latch !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (scan_done === 1'b1 || buttons !== held) spurious = 1'b1;
        end
        total++;
        if (n !== POLL_PERIOD || spurious) begin
            bad++;
            $display("FAIL abort_relatch: %0d cycles spurious=%0d required %0d 0",
                     n, spurious, POLL_PERIOD);
        end
        push_scan(8'hFF);
        finish_scan(got, want, ok, moved, sd);
        total++;
        if (!ok || got !== want || got !== held) begin
            bad++;
            $display("FAIL abort_next_scan: ok=%0d buttons=%h required 1 %h", ok, got, want);
        end
    endtask

    task automatic test_async_reset();
        int n;
        logic [7:0] got, want;
        bit ok, moved;
        logic sd;
        for (int k = 0; k < 2; k++) begin
            push_scan(8'h77);
            finish_scan(got, want, ok, moved, sd);
            total++;
            if (!ok || got !== want) begin
                bad++;
                $display("FAIL st_rt_%0d: ok=%0d buttons=%h required 1 %h", k, ok, got, want);
            end
        end
        total++;
        if (buttons !== 8'h7E) begin
            bad++;
            $display("FAIL st_rt_final: buttons=%h required 7e", buttons);
        end
        wait_latch(300, n);
        n = 0;
        while (pad.pad_clk !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (buttons !== 8'hFF || pad.pad_clk !== 1'b1 || pad.pad_latch !== 1'b0 ||
            scan_done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: buttons=%h clk=%b latch=%b done=%b required ff 1 0 0",
                     buttons, pad.pad_clk, pad.pad_latch, scan_done);
        end
        m_prev = 8'hFF;
        m_btn  = 8'hFF;
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        wait_latch(300, n);
        total++;
        if (n !== POLL_PERIOD) begin
            bad++;
            $display("FAIL reset_relatch: %0d cycles required %0d", n, POLL_PERIOD);
        end
        push_scan(8'hFF);
        finish_scan(got, want, ok, moved, sd);
        total++;
        if (!ok || got !== want || got !== 8'hFF) begin
            bad++;
            $display("FAIL post_reset_scan: ok=%0d buttons=%h required 1 %h", ok, got, want);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_bounce();
        test_press_a();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
